fetch_stage: RTL and testbench

Instruction-fetch control stage. It sits between the 32-bit program counter register and the decode stage. It consumes the current PC (PCResult) and drives the next-PC value (Address) back into the PC register every cycle. It also runs the request/ready handshake to instruction memory and owns the IF/ID pipeline register, with stall, flush and branch/jump redirect support.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_hold_buffer.sv | 41 ++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

  // Redirect targets are word aligned by dropping the two low bits.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry buffer that parks a fetched word while the pipeline is stalled.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                drain,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] next_instr,
  input  logic [PC_WIDTH-1:0] next_pc_plus4,
  output logic [PC_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  logic                full;
  logic [PC_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0] pc_plus4_q;

  // Load captures a word; drain or clear empties the entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full       <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
    end else if (load) begin
      full       <= 1'b1;
      instr_q    <= next_instr;
      pc_plus4_q <= next_pc_plus4;
    end else if (drain) begin
      full       <= 1'b0;
    end
  end

  // An empty entry reads back as a NOP so stale data never leaks out.
  always_comb begin
    instr    = full ? instr_q    : NOP_INSTR;
    pc_plus4 = full ? pc_plus4_q : '0;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch control: next-PC select, imem handshake and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] PC_INCR  = 32'd4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PC_WIDTH-1:0] PCResult,
  output logic [PC_WIDTH-1:0] Address,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [PC_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc_plus4,
  output logic                ifid_valid,
  output logic                fetch_busy
);

  fetch_state_t        state, next_state;
  logic [PC_WIDTH-1:0] pending_target, pending_next;
  logic [PC_WIDTH-1:0] target, pc_plus_incr;
  logic [PC_WIDTH-1:0] buf_instr, buf_pc_plus4;
  logic                cap_mem, cap_buf, bubble;
  logic                buf_load, buf_drain, buf_clear;

  assign target       = align_pc(redirect_target);
  assign pc_plus_incr = PCResult + PC_INCR;
  assign imem_addr    = PCResult;
  assign fetch_busy   = imem_req && ((state == FETCH) || (state == SQUASH));

  fetch_hold_buffer u_hold (
    .clk           (Clk),
    .reset         (Reset),
    .load          (buf_load),
    .drain         (buf_drain),
    .clear         (buf_clear),
    .next_instr    (imem_rdata),
    .next_pc_plus4 (pc_plus_incr),
    .instr         (buf_instr),
    .pc_plus4      (buf_pc_plus4)
  );

  // State and pending redirect target registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= FETCH;
      pending_target <= '0;
    end else begin
      state          <= next_state;
      pending_target <= pending_next;
    end
  end

  // Next-state, next-PC and IF/ID control. The PC register has no enable,
  // so every "hold" path feeds PCResult straight back on Address.
  always_comb begin
    next_state   = state;
    pending_next = pending_target;
    Address      = PCResult;
    imem_req     = 1'b0;
    cap_mem      = 1'b0;
    cap_buf      = 1'b0;
    bubble       = 1'b0;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    buf_clear    = 1'b0;
    if (Reset) begin
      Address    = RESET_PC;
      next_state = FETCH;
    end else begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (!imem_ready) begin
            if (redirect_valid) begin
              pending_next = target;
              next_state   = SQUASH;
              bubble       = 1'b1;
            end else if (!stall) begin
              bubble = 1'b1;
            end
          end else if (redirect_valid) begin
            Address = target;
            bubble  = 1'b1;
          end else if (stall) begin
            buf_load   = 1'b1;
            next_state = HOLD;
          end else begin
            cap_mem = 1'b1;
            Address = pc_plus_incr;
          end
        end
        SQUASH: begin
          // The in-flight read must complete before the new address is issued.
          imem_req = 1'b1;
          bubble   = 1'b1;
          if (redirect_valid) begin
            pending_next = target;
          end
          if (imem_ready) begin
            Address    = redirect_valid ? target : pending_target;
            next_state = FETCH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            buf_clear  = 1'b1;
            Address    = target;
            next_state = FETCH;
          end else if (!stall) begin
            cap_buf    = 1'b1;
            buf_drain  = 1'b1;
            Address    = pc_plus_incr;
            next_state = FETCH;
          end
        end
        default: next_state = FETCH;
      endcase
    end
  end

  // IF/ID pipeline register; flush overrides any capture or hold.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      if (cap_mem) begin
        ifid_instr    <= imem_rdata;
        ifid_pc_plus4 <= pc_plus_incr;
        ifid_valid    <= 1'b1;
      end else if (cap_buf) begin
        ifid_instr    <= buf_instr;
        ifid_pc_plus4 <= buf_pc_plus4;
        ifid_valid    <= 1'b1;
      end else if (bubble) begin
        ifid_valid    <= 1'b0;
      end
      if (flush) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] PAT    = 32'hA5A5_A5A5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] pc;
  logic [31:0] Address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, fetch_busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_tgt, m_hw, m_hp4, m_ifi, m_ifp;
  bit          m_sq, m_held, m_ifv, m_ifi_k, m_ifp_k;

  always #5 Clk = ~Clk;

  // PC register (no enable) and instruction memory contents.
  always @(posedge Clk) pc <= Reset ? RST_PC : Address;
  assign imem_rdata = imem_addr ^ PAT;

  fetch_stage #(.RESET_PC(RST_PC), .PC_INCR(32'd4)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .PCResult        (pc),
    .Address         (Address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .fetch_busy      (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sq = 0; m_held = 0; m_ifv = 0;
    m_ifi = 32'h0; m_ifp = 32'h0; m_ifi_k = 1; m_ifp_k = 1;
    m_tgt = 32'h0; m_hw = 32'h0; m_hp4 = 32'h0;
  endtask

  task automatic drop_ifid();
    m_ifv = 0; m_ifi_k = 0; m_ifp_k = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit rst, input bit rdy, input bit st, input bit fl,
                       input bit rv, input logic [31:0] rt);
    logic [31:0] tgt, e_addr;
    bit          e_req;
    Reset = rst; imem_ready = rdy; stall = st; flush = fl;
    redirect_valid = rv; redirect_target = rt;
    tgt = rt & 32'hFFFF_FFFC;
    @(negedge Clk);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
    if (m_ifi_k) chk("ifid_instr", ifid_instr, m_ifi);
    if (m_ifp_k) chk("ifid_pc_plus4", ifid_pc_plus4, m_ifp);
    chk("imem_addr", imem_addr, m_pc);
    e_req  = !rst && !m_held;
    e_addr = m_pc;
    if (rst) begin
      e_addr = RST_PC;
      model_reset();
    end else begin
      if (m_held) begin
        if (rv) begin
          e_addr = tgt; m_held = 0;
        end else if (!st) begin
          m_ifi = m_hw; m_ifp = m_hp4; m_ifv = 1; m_ifi_k = 1; m_ifp_k = 1;
          e_addr = m_pc + 32'd4; m_held = 0;
        end
      end else if (m_sq) begin
        drop_ifid();
        if (rv) m_tgt = tgt;
        if (rdy) begin
          e_addr = m_tgt; m_sq = 0;
        end
      end else if (!rdy) begin
        if (rv) begin
          m_sq = 1; m_tgt = tgt; drop_ifid();
        end else if (!st) begin
          drop_ifid();
        end
      end else if (rv) begin
        e_addr = tgt; drop_ifid();
      end else if (st) begin
        m_held = 1; m_hw = m_pc ^ PAT; m_hp4 = m_pc + 32'd4;
      end else begin
        m_ifi = m_pc ^ PAT; m_ifp = m_pc + 32'd4; m_ifv = 1; m_ifi_k = 1; m_ifp_k = 1;
        e_addr = m_pc + 32'd4;
      end
      if (fl) begin
        m_ifv = 0; m_ifi = 32'h0; m_ifi_k = 1; m_ifp_k = 0;
      end
    end
    chk("Address", Address, e_addr);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("fetch_busy", 32'(fetch_busy), 32'(e_req));
    m_pc = e_addr;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1; imem_ready = 0; stall = 0; flush = 0;
    redirect_valid = 0; redirect_target = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    m_pc = RST_PC;
    model_reset();

    // Reset state
    cycle(1, 0, 0, 0, 0, 32'h0);

    // Zero-wait sequential fetch
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 32'h0);
    chk("seq_pc_plus4", ifid_pc_plus4, 32'd16);

    // Two wait states at PC 8
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);
    chk("wait_pc_plus4", ifid_pc_plus4, 32'd12);
    cycle(0, 1, 0, 0, 0, 32'h0);

    // Stall coincident with ready at PC 4
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(0, 1, 1, 0, 0, 32'h0);
    cycle(0, 0, 1, 0, 0, 32'h0);
    cycle(0, 1, 1, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0);
    chk("hold_instr", ifid_instr, 32'h4 ^ PAT);
    chk("hold_pc_plus4", ifid_pc_plus4, 32'd8);

    // Redirect while waiting at PC 16
    cycle(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0103);
    cycle(0, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);
    chk("squash_pc", pc, 32'h0000_0100);
    cycle(0, 1, 0, 0, 0, 32'h0);

    // Redirect with ready plus flush
    cycle(0, 1, 0, 1, 1, 32'h0000_0200);
    cycle(0, 1, 0, 0, 0, 32'h0);

    // Wrap from 0xFFFFFFFC
    cycle(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0, 0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Reset during SQUASH at 0xFFFFFFFC
    cycle(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1, 32'h0000_0040);
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0),
            $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
